// File: rtl/lamp_pkg.sv
// Shared types and field positions for the lamp sequencer.
// Config entry: pattern in the high nibble, hold ticks in the low nibble (0 = end).
package lamp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_HOLD,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam int PAT_MSB  = 7;
  localparam int PAT_LSB  = 4;
  localparam int HOLD_MSB = 3;
  localparam int HOLD_LSB = 0;
  localparam int ADDR_W   = 4;

endpackage

// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizer, optional debounce, rising-edge press pulse.
// Latency: 2 cycles to a press pulse (plus DEBOUNCE_CYCLES with LAMP_SEQ_DEBOUNCE_EN).
// No backpressure: press is a one-cycle pulse that the consumer may ignore.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1, sync2, level, level_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

`ifdef LAMP_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] stable_cnt;
  logic          deb;

  // The accepted level flips only after the new level has been seen DEBOUNCE_CYCLES times in a row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable_cnt <= '0;
      deb        <= 1'b0;
    end else if (sync2 == deb) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      deb        <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign level = deb;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/lamp_sequencer.sv
// Steps lamp patterns from a config memory, holding each for hold*TICK_DIV cycles; pause/resume by button.
// Latency: fetch-to-lamp 2 cycles, 2 cycles overhead per step. Optional LAMP_SEQ_DEBOUNCE_EN on the button.
// No backpressure: the config memory is assumed to return data one cycle after cfg_addr.
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int TICK_DIV        = 1000,
  parameter int NUM_STEPS       = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              button,
  output logic [ADDR_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic [3:0]        lamp,
  output logic [3:0]        step_count,
  output logic              running,
  output logic              reached
);

  if (TICK_DIV < 2 || NUM_STEPS < 1 || NUM_STEPS > 15) begin : g_bad_params
    $error("lamp_sequencer: TICK_DIV must be >= 2 and NUM_STEPS in 1..15");
  end

  localparam int PW = $clog2(TICK_DIV);

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    tick_cnt;
  logic          press;
  logic [3:0]    pat_f, hold_f, step_next;
  logic          presc_wrap, hold_last;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clock  (clock),
    .reset  (reset),
    .button (button),
    .press  (press)
  );

  assign pat_f      = cfg_data[PAT_MSB:PAT_LSB];
  assign hold_f     = cfg_data[HOLD_MSB:HOLD_LSB];
  assign step_next  = step_count + 4'd1;
  assign presc_wrap = (presc == PW'(TICK_DIV - 1));
  assign hold_last  = presc_wrap && (tick_cnt == 4'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cfg_addr   <= '0;
      lamp       <= '0;
      step_count <= '0;
      running    <= 1'b0;
      reached    <= 1'b0;
      presc      <= '0;
      tick_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (press) begin
          cfg_addr   <= '0;
          step_count <= '0;
          running    <= 1'b1;
          state      <= ST_FETCH;
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          if (hold_f != 4'd0) begin
            lamp     <= pat_f;
            tick_cnt <= hold_f;
            presc    <= '0;
            state    <= ST_HOLD;
          end else if (cfg_addr != '0) begin
            cfg_addr <= '0;
            state    <= ST_FETCH;
          end else begin
            running <= 1'b0;
            reached <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_HOLD: begin
          // Expiry takes priority; a press in the same cycle is dropped.
          if (hold_last) begin
            step_count <= step_next;
            cfg_addr   <= cfg_addr + 1'b1;
            presc      <= '0;
            if (step_next == 4'(NUM_STEPS)) begin
              running <= 1'b0;
              reached <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_FETCH;
            end
          end else begin
            if (presc_wrap) begin
              presc    <= '0;
              tick_cnt <= tick_cnt - 4'd1;
            end else begin
              presc <= presc + 1'b1;
            end
            if (press) begin
              running <= 1'b0;
              state   <= ST_PAUSE;
            end
          end
        end
        ST_PAUSE: if (press) begin
          running <= 1'b1;
          state   <= ST_HOLD;
        end
        ST_DONE: if (press) begin
          lamp       <= '0;
          step_count <= '0;
          cfg_addr   <= '0;
          reached    <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer with TICK_DIV=2, NUM_STEPS=8 and a synchronous-read config memory.
module tb_lamp_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data = 8'h00;
  logic [3:0] lamp;
  logic [3:0] step_count;
  logic       running;
  logic       reached;

  logic [7:0] mem [16];
  int nchecks = 0;
  int nerrors = 0;

`ifdef LAMP_SEQ_DEBOUNCE_EN
  localparam int PRESS_CYC = 20;
`else
  localparam int PRESS_CYC = 3;
`endif

  lamp_sequencer #(.TICK_DIV(2), .NUM_STEPS(8), .DEBOUNCE_CYCLES(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .button     (button),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .lamp       (lamp),
    .step_count (step_count),
    .running    (running),
    .reached    (reached)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cfg_data <= mem[cfg_addr];

  task automatic check(input string tag, input int got, input int exp);
    nchecks++;
    if (got != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic press_btn();
    button = 1'b1;
    repeat (PRESS_CYC) tick();
    button = 1'b0;
    repeat (PRESS_CYC) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load_std();
    for (int a = 0; a < 16; a++) mem[a] = 8'h13;
    mem[0] = 8'h13; mem[1] = 8'h22; mem[2] = 8'h41; mem[3] = 8'h00;
  endtask

  task automatic wait_reached(output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (reached) ok = 1;
    end
  endtask

  initial begin
    int first_run, first_lamp, first_done, c1, c2, c3, n1, n2, bad;
    bit seen3, ok;

    load_std();
    repeat (3) tick();
    check("rst_lamp", lamp, 0);
    check("rst_addr", cfg_addr, 0);
    check("rst_step", step_count, 0);
    check("rst_running", running, 0);
    check("rst_reached", reached, 0);
    reset = 1'b1;
    tick();

`ifdef LAMP_SEQ_DEBOUNCE_EN
    button = 1'b1; repeat (5) tick(); button = 1'b0;
    repeat (40) tick();
    check("deb_glitch_no_start", running, 0);
    button = 1'b1; ok = 0;
    for (int i = 1; i <= 60 && !ok; i++) begin
      tick();
      if (i == 20) button = 1'b0;
      if (running) ok = 1;
    end
    button = 1'b0;
    check("deb_press_starts", ok, 1);
    do_reset();
`endif

    // Normal sequence: hold widths, latency, hold-0 wrap, then completion.
    first_run = -1; first_lamp = -1; c1 = 0; c2 = 0; c3 = 0; seen3 = 0; ok = 0;
    button = 1'b1;
    for (int i = 1; i <= 300 && !ok; i++) begin
      tick();
      if (i == PRESS_CYC) button = 1'b0;
      if (running && first_run < 0) first_run = i;
      if (lamp != 0 && first_lamp < 0) first_lamp = i;
      if (running && lamp == 1 && cfg_addr == 0) c1++;
      if (running && lamp == 2 && cfg_addr == 1) c2++;
      if (running && lamp == 4 && cfg_addr == 2) c3++;
      if (cfg_addr == 3) seen3 = 1;
      if (seen3 && cfg_addr == 0) ok = 1;
    end
    check("norm_wrap_seen", ok, 1);
    check("norm_start_latency", first_run, 3);
    check("norm_lamp_latency", first_lamp, 5);
    check("norm_hold_p1", c1, 6);
    check("norm_hold_p2", c2, 4);
    check("norm_hold_p4", c3, 2);
    check("norm_wrap_step", step_count, 3);
    check("norm_wrap_lamp", lamp, 4);
    check("norm_wrap_running", running, 1);
    wait_reached(ok);
    check("norm_done_seen", ok, 1);
    check("norm_done_step", step_count, 8);
    check("norm_done_addr", cfg_addr, 2);
    check("norm_done_lamp", lamp, 2);
    press_btn();
    check("norm_clear_lamp", lamp, 0);
    check("norm_clear_step", step_count, 0);
    check("norm_clear_addr", cfg_addr, 0);
    check("norm_clear_reached", reached, 0);

    // Completion with sixteen identical entries.
    do_reset();
    for (int a = 0; a < 16; a++) mem[a] = 8'h51;
    press_btn();
    wait_reached(ok);
    check("comp_done_seen", ok, 1);
    check("comp_addr", cfg_addr, 8);
    check("comp_lamp", lamp, 5);
    check("comp_step", step_count, 8);
    check("comp_running", running, 0);
    press_btn();
    check("comp_clear_reached", reached, 0);
    check("comp_clear_lamp", lamp, 0);
    check("comp_clear_addr", cfg_addr, 0);

    // Empty sequence guard.
    do_reset();
    mem[0] = 8'h70;
    first_run = -1; first_done = -1;
    button = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == PRESS_CYC) button = 1'b0;
      if (running && first_run < 0) first_run = i;
      if (reached && first_done < 0) first_done = i;
    end
    check("empty_done_seen", first_done > 0, 1);
    check("empty_fetch_to_done", first_done - first_run, 2);
    check("empty_step", step_count, 0);
    check("empty_lamp", lamp, 0);

    // Pause at 3 of 6 hold cycles, resume after 50 cycles.
    do_reset();
    load_std();
    ok = 0;
    button = 1'b1;
    for (int i = 1; i <= 40 && !ok; i++) begin
      tick();
      if (i == PRESS_CYC) button = 1'b0;
      if (lamp == 1) ok = 1;
    end
    check("pause_lamp_seen", ok, 1);
    button = 1'b1;
    n1 = 0;
    for (int k = 0; k < 20 && running; k++) begin
      n1++;
      tick();
    end
    button = 1'b0;
    check("pause_hold_before", n1, 3);
    bad = 0;
    repeat (50) begin
      tick();
      if (lamp != 1 || running) bad++;
    end
    check("pause_frozen_bad_cycles", bad, 0);
    button = 1'b1;
    n2 = 0; ok = 0;
    for (int i = 1; i <= 60 && !ok; i++) begin
      tick();
      if (i == PRESS_CYC) button = 1'b0;
      if (running && lamp == 1 && cfg_addr == 0) n2++;
      if (cfg_addr == 1) ok = 1;
    end
    button = 1'b0;
    check("pause_resumed", ok, 1);
    check("pause_hold_after", n2, 3);
    check("pause_lamp_kept", lamp, 1);

    // Reset asserted during the second step.
    do_reset();
    load_std();
    press_btn();
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (lamp == 2) ok = 1;
    end
    check("rmid_step2_seen", ok, 1);
    tick();
    reset = 1'b0;
    #1;
    check("rmid_lamp", lamp, 0);
    check("rmid_addr", cfg_addr, 0);
    check("rmid_step", step_count, 0);
    check("rmid_running", running, 0);
    check("rmid_reached", reached, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (20) tick();
    check("rmid_idle_running", running, 0);
    check("rmid_idle_lamp", lamp, 0);
    check("rmid_idle_addr", cfg_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/lamp_sequencer.md
LAMP_SEQUENCER -- requirements
Module: lamp_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1000, gives the clocks per hold tick and SHALL be 2 or more.
REQ-002 Parameter NUM_STEPS, default 8, gives the completed steps before DONE and SHALL be in the range 1..15.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, gives the stable-level cycles required on button; it is used only with LAMP_SEQ_DEBOUNCE_EN.
REQ-004 Port clock  in  1  is the single clock; all logic is on the rising edge.
REQ-005 Port reset  in  1  is the asynchronous, active-low reset.
REQ-006 Port button  in  1  is the raw, asynchronous push-button input.
REQ-007 Port cfg_addr  out  4  is the config memory address, registered.
REQ-008 Port cfg_data  in  8  is the config memory read data, valid the cycle after cfg_addr is sampled.
REQ-009 Port lamp  out  4  is the lamp drive, registered.
REQ-010 Port step_count  out  4  is the number of steps completed.
REQ-011 Port running  out  1  is high in the FETCH, LOAD and HOLD states.
REQ-012 Port reached  out  1  is a level, high in the DONE state.

Function
REQ-013 The button input SHALL pass through a 2-flop synchronizer; a press is a single-cycle rising edge of the synchronized (or debounced) level.
REQ-014 Config entry format SHALL be: cfg_data[7:4] = lamp pattern, cfg_data[3:0] = hold in ticks, where hold 0 marks end of sequence.
REQ-015 The FSM states SHALL be IDLE, FETCH, LOAD, HOLD, PAUSE and DONE.
REQ-016 IDLE: on a press, set cfg_addr=0 and step_count=0, then go to FETCH.
REQ-017 FETCH: lasts exactly one cycle with cfg_addr stable, then goes to LOAD.
REQ-018 LOAD: samples cfg_data at the end of the cycle.
REQ-019 LOAD with hold != 0: lamp <= pattern in that same edge; load the tick counter; go to HOLD.
REQ-020 LOAD with hold == 0 and cfg_addr != 0: set cfg_addr=0, leave step_count unchanged, go to FETCH.
REQ-021 LOAD with hold == 0 and cfg_addr == 0: go to DONE (empty sequence guard).
REQ-022 HOLD: lasts exactly hold*TICK_DIV cycles, counted by an internal prescaler and tick counter.
REQ-023 HOLD expiry: increment step_count; cfg_addr increments modulo 16 (15 wraps to 0).
REQ-024 HOLD expiry when step_count becomes NUM_STEPS: go to DONE; otherwise go to FETCH.
REQ-025 A press in HOLD SHALL go to PAUSE with both counters frozen and lamp held.
REQ-026 A press in PAUSE SHALL return to HOLD and resume the remaining count exactly.
REQ-027 A press in FETCH or LOAD SHALL be ignored.
REQ-028 DONE: lamp holds the last pattern; a press clears lamp, step_count and cfg_addr to 0 and goes to IDLE.
REQ-029 If a press and HOLD expiry occur in the same cycle, the expiry SHALL win and the press SHALL be discarded.
REQ-030 Fetch-to-lamp latency SHALL be 2 cycles (FETCH edge plus LOAD edge).
REQ-031 Step-to-step overhead beyond the hold time SHALL be exactly 2 cycles.

Reset
REQ-032 Asserting reset SHALL asynchronously force IDLE with lamp=0, cfg_addr=0, step_count=0, running=0, reached=0, and clear all counters, synchronizer and debounce state.
REQ-033 Reset asserted mid-sequence SHALL abandon the sequence; after reset release, a new press is required to start.

Configuration
REQ-034 With LAMP_SEQ_DEBOUNCE_EN defined, the synchronized button SHALL be accepted only after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
REQ-035 Without LAMP_SEQ_DEBOUNCE_EN, the synchronized button SHALL be used directly, with 2-cycle input latency.

Structure
REQ-036 A shared package lamp_pkg SHALL hold the FSM state enum, the entry field positions (PAT_MSB/LSB, HOLD_MSB/LSB) and the address width constant (4).
REQ-037 One sub-module, button_conditioner, SHALL contain the synchronizer, the optional debounce and the edge detect, and output a single-cycle press pulse.

Verification
REQ-038 Scenario, normal sequence: TICK_DIV=2; memory {0x13,0x22,0x41,0x00}; press. Required: lamp=1 for 6 cycles, then 2 for 4, then 4 for 2; then the hold-0 entry wraps cfg_addr to 0 with step_count=3.
REQ-039 Scenario, completion: memory of 16 entries, each 0x51, NUM_STEPS=8. Required: reached=1 after the 8th step; cfg_addr=8; lamp=5; further presses clear to IDLE.
REQ-040 Scenario, pause and resume: press mid-HOLD at 3 of 6 cycles, wait 50 cycles, press again. Required: lamp is unchanged throughout; exactly 3 more HOLD cycles elapse before FETCH.
REQ-041 Scenario, empty sequence guard: entry 0 = 0x70. Required: DONE 2 cycles after FETCH with step_count=0.
REQ-042 Scenario, reset mid-sequence: reset low during HOLD at step 2. Required: all outputs are 0 immediately (asynchronously) and the block stays in IDLE after release.
REQ-043 Scenario, debounce: with LAMP_SEQ_DEBOUNCE_EN, a glitch of 5 cycles shorter than DEBOUNCE_CYCLES=16 yields no start. Required: a 20-cycle press starts the sequence.
